// File: rtl/mem_pkg.sv
// Shared definitions for the instruction memory responder and its storage array.
package mem_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Width of a word index into a DEPTH_WORDS-deep memory (at least one bit).
  function automatic int index_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Program storage: DEPTH_WORDS x 32 words, synchronous write and asynchronous read.
module instr_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int INDEX_WIDTH = index_width(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [WORD_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [WORD_WIDTH-1:0]  rd_data
);

  logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side memory responder: accepts word reads, answers after LATENCY cycles
// with a one-cycle valid pulse, and flags misaligned or out-of-range addresses.
module instr_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  output logic                  ready,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  valid,
  output logic                  error,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data
);

  localparam int INDEX_WIDTH = index_width(DEPTH_WORDS);
  localparam int INDEX_TOP   = INDEX_WIDTH + 2;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  resp_state_t state, state_next;
  logic [3:0] count, count_next;
  logic [WORD_WIDTH-1:0] instr_q;
  logic err_q;

  logic [INDEX_WIDTH-1:0] rd_index, wr_index;
  logic [WORD_WIDTH-1:0] rd_data;
  logic rd_in_range, wr_in_range;
  logic misaligned, bad_access, accept;
  logic unused_wr_low;

  // DEPTH_WORDS is a power of two, so "index < DEPTH_WORDS" reduces to the
  // bits above the index being zero.
  if (ADDR_WIDTH > INDEX_TOP) begin : g_range
    assign rd_in_range = (address[ADDR_WIDTH-1:INDEX_TOP] == '0);
    assign wr_in_range = (wr_addr[ADDR_WIDTH-1:INDEX_TOP] == '0);
  end else begin : g_full
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
  end

  assign rd_index      = address[INDEX_TOP-1:2];
  assign wr_index      = wr_addr[INDEX_TOP-1:2];
  assign unused_wr_low = ^wr_addr[1:0];

  assign misaligned = |address[1:0];
  assign bad_access = misaligned || !rd_in_range;

  assign ready       = reset_n && (state != BUSY);
  assign accept      = read && ready;
  assign valid       = (state == RESP);
  assign error       = valid && err_q;
  assign instruction = instr_q;

  instr_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en && wr_in_range),
    .wr_index(wr_index),
    .wr_data (wr_data),
    .rd_index(rd_index),
    .rd_data (rd_data)
  );

  // IDLE and RESP both accept; RESP without a new request falls back to IDLE.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      BUSY: begin
        count_next = count - 4'd1;
        if (count <= 4'd1) begin
          state_next = RESP;
        end
      end
      default: begin
        if (accept) begin
          count_next = COUNT_LOAD;
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end else if (state == RESP) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // The word is captured at acceptance, so a write on the same edge is not seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        instr_q <= bad_access ? NOP_INSTR : rd_data;
        err_q   <= bad_access;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 3) share stimulus and are
// compared against a timestamp-based reference model plus directed scenarios.
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic        rdy [3];
  logic        vld [3];
  logic        err [3];
  logic [31:0] ins [3];

  int checks = 0;
  int failures = 0;
  logic [31:0] last_word;

  // Reference model state: a pending response becomes visible once edge_n
  // reaches its due edge number.
  logic [31:0] mem_model [1024];
  bit          m_pending [3];
  int          m_due [3];
  logic [31:0] m_data [3];
  bit          m_err [3];
  int          edge_n = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .ready(rdy[0]),
    .instruction(ins[0]), .valid(vld[0]), .error(err[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  instr_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .ready(rdy[1]),
    .instruction(ins[1]), .valid(vld[1]), .error(err[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  instr_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .ready(rdy[2]),
    .instruction(ins[2]), .valid(vld[2]), .error(err[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  function automatic int lat_of(input int i);
    return i + 1;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  function automatic bit model_valid(input int i);
    return m_pending[i] && (m_due[i] == edge_n);
  endfunction

  function automatic bit model_ready(input int i);
    return reset_n && (!m_pending[i] || (m_due[i] == edge_n));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) m_pending[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (read && model_ready(i)) begin
          m_pending[i] = 1'b1;
          m_due[i]     = edge_n + lat_of(i);
          m_err[i]     = addr_bad(address);
          m_data[i]    = m_err[i] ? NOP : mem_model[address[11:2]];
        end else if (model_valid(i)) begin
          m_pending[i] = 1'b0;
        end
      end
      if (wr_en && (wr_addr < 32'd4096)) mem_model[wr_addr[11:2]] = wr_data;
      edge_n++;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready dut=%0d got=%b exp=0", i, rdy[i]); end
      checks++;
      if (vld[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid dut=%0d got=%b exp=0", i, vld[i]); end
      checks++;
      if (err[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_error dut=%0d got=%b exp=0", i, err[i]); end
      checks++;
      if (ins[i] !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr dut=%0d got=%h exp=0", i, ins[i]); end
    end
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin failures++; $display("[TB] FAIL release_ready dut=%0d got=%b exp=1", i, rdy[i]); end
    end
  endtask

  task automatic preload();
    logic [31:0] d;
    for (int w = 0; w < 1024; w++) begin
      @(negedge clk);
      d = (w < 4) ? 32'(32'h11 * (w + 1)) : $urandom;
      wr_en = 1'b1;
      wr_addr = 32'(w * 4);
      wr_data = d;
      if (w == 1023) last_word = d;
    end
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Read held high; the next address is presented whenever the target is ready.
  task automatic test_stream(input int dut, input int n);
    int issued = 0;
    int got = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic [31:0] exp_w;
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (vld[dut] === 1'b1) begin
        exp_w = 32'(32'h11 * (got + 1));
        checks++;
        if (ins[dut] !== exp_w) begin failures++; $display("[TB] FAIL stream_data dut=%0d idx=%0d got=%h exp=%h", dut, got, ins[dut], exp_w); end
        checks++;
        if (err[dut] !== 1'b0) begin failures++; $display("[TB] FAIL stream_error dut=%0d idx=%0d got=%b exp=0", dut, got, err[dut]); end
        if (got > 0) begin
          checks++;
          if (cyc - last_cyc != lat_of(dut)) begin failures++; $display("[TB] FAIL stream_spacing dut=%0d got=%0d exp=%0d", dut, cyc - last_cyc, lat_of(dut)); end
        end
        last_cyc = cyc;
        got++;
      end
      if (rdy[dut] === 1'b1 && issued < n) begin
        address = 32'(issued * 4);
        read = 1'b1;
        issued++;
      end else if (rdy[dut] === 1'b1) begin
        read = 1'b0;
      end
    end
    checks++;
    if (got != n) begin failures++; $display("[TB] FAIL stream_timeout dut=%0d got=%0d exp=%0d", dut, got, n); end
    read = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // One request to every (idle) responder; each must answer exactly LATENCY cycles later.
  task automatic test_single(input logic [31:0] addr, input logic [31:0] exp_ins, input bit exp_err,
                             input bit do_wr, input logic [31:0] waddr, input logic [31:0] wdata,
                             input string name);
    bit exp_v;
    @(negedge clk);
    address = addr;
    read = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1;
      wr_addr = waddr;
      wr_data = wdata;
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        exp_v = (k == lat_of(i));
        checks++;
        if (vld[i] !== exp_v) begin failures++; $display("[TB] FAIL %s_valid dut=%0d k=%0d got=%b exp=%b", name, i, k, vld[i], exp_v); end
        if (exp_v) begin
          checks++;
          if (ins[i] !== exp_ins) begin failures++; $display("[TB] FAIL %s_instr dut=%0d got=%h exp=%h", name, i, ins[i], exp_ins); end
          checks++;
          if (err[i] !== exp_err) begin failures++; $display("[TB] FAIL %s_error dut=%0d got=%b exp=%b", name, i, err[i], exp_err); end
        end
      end
      if (k == 1) begin
        read = 1'b0;
        wr_en = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    address = 32'h0;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (rdy[2] !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy dut=2 got=%b exp=0", rdy[2]); end
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b0 || vld[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrst_asserted dut=%0d got=%b%b exp=00", i, rdy[i], vld[i]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin failures++; $display("[TB] FAIL midrst_release_ready dut=%0d got=%b exp=1", i, rdy[i]); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vld[i] !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_valid dut=%0d k=%0d got=%b exp=0", i, k, vld[i]); end
      end
    end
  endtask

  task automatic test_random(input int n);
    int kind;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rdy[i] !== model_ready(i)) begin failures++; $display("[TB] FAIL rnd_ready dut=%0d cyc=%0d got=%b exp=%b", i, c, rdy[i], model_ready(i)); end
        checks++;
        if (vld[i] !== model_valid(i)) begin failures++; $display("[TB] FAIL rnd_valid dut=%0d cyc=%0d got=%b exp=%b", i, c, vld[i], model_valid(i)); end
        if (model_valid(i)) begin
          checks++;
          if (ins[i] !== m_data[i]) begin failures++; $display("[TB] FAIL rnd_instr dut=%0d cyc=%0d got=%h exp=%h", i, c, ins[i], m_data[i]); end
          checks++;
          if (err[i] !== m_err[i]) begin failures++; $display("[TB] FAIL rnd_error dut=%0d cyc=%0d got=%b exp=%b", i, c, err[i], m_err[i]); end
        end else begin
          checks++;
          if (err[i] !== 1'b0) begin failures++; $display("[TB] FAIL rnd_error_idle dut=%0d cyc=%0d got=%b exp=0", i, c, err[i]); end
        end
      end
      read = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      if (kind < 7)       address = 32'($urandom_range(0, 1023) * 4);
      else if (kind == 7) address = 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
      else                address = 32'h1000 + $urandom_range(0, 32'h0FFF_FFFF);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_addr = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 4095) : $urandom_range(4096, 32'h000F_FFFF);
      wr_data = $urandom;
    end
    read = 1'b0;
    wr_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    preload();
    test_stream(1, 4);
    test_stream(0, 3);
    test_single(32'h0000_0002, NOP, 1'b1, 1'b0, 32'h0, 32'h0, "misaligned");
    test_single(32'h0000_1000, NOP, 1'b1, 1'b0, 32'h0, 32'h0, "out_of_range");
    test_single(32'h0000_0FFC, last_word, 1'b0, 1'b0, 32'h0, 32'h0, "last_word");
    test_single(32'h0000_0008, 32'h33, 1'b0, 1'b1, 32'h8, 32'hDEAD, "rbw_old");
    test_single(32'h0000_0008, 32'hDEAD, 1'b0, 1'b0, 32'h0, 32'h0, "rbw_new");
    test_reset_mid();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
